erm16_bus_arbiter: RTL and testbench
====================================

ERM16_BUS_ARBITER -- requirements
Module: erm16_bus_arbiter

Interface
REQ-001 Parameter WAIT_STATES, default 1, memory wait cycles per access, legal range 0..15.
REQ-002 clk  input  1  single system clock, rising-edge active.
REQ-003 init  input  1  reset, asynchronous, active-high.
REQ-004 cpu_req / cpu_we  input  1 each  CPU access request / write qualifier.
REQ-005 cpu_addr / cpu_wdata  input  16 each  CPU address / write data.
REQ-006 cpu_ack  output  1  one-cycle CPU completion pulse.
REQ-007 dma_req / dma_we  input  1 each  DMA access request / write qualifier.
REQ-008 dma_addr / dma_wdata  input  16 each  DMA address / write data.
REQ-009 dma_ack  output  1  one-cycle DMA completion pulse.
REQ-010 rdata  output  16  read data, valid in the ack cycle, shared by both requesters.
REQ-011 mem_addr / mem_do  output  16 each  memory address / write data.
REQ-012 mem_wr  output  1  memory write strobe.
REQ-013 mem_di  input  16  memory read data.
REQ-014 grant / busy  output  1 each  current owner (0=CPU, 1=DMA) / transaction in progress.

Function
REQ-015 FSM states IDLE, WAIT, ACK; all outputs driven from registers.
REQ-016 IDLE: no request -> stay; any request -> select winner, latch its addr, wdata, we into mem_addr, mem_do and internal we, set grant, load cnt=WAIT_STATES, go WAIT.
REQ-017 WAIT: cnt!=0 -> cnt-1, stay; cnt==0 -> capture mem_di into rdata if latched we=0, go ACK.
REQ-018 mem_wr high during every WAIT cycle of a write, low otherwise.
REQ-019 ACK: assert winner's ack for exactly one cycle, go IDLE unconditionally; requests sampled in ACK ignored.
REQ-020 Latency: request sampled at IDLE edge k -> ack high in cycle after edge k+WAIT_STATES+1; next arbitration no earlier than edge k+WAIT_STATES+2.
REQ-021 Requester holds req and operands until ack; dropping req after grant does not abort, ack still pulses.
REQ-022 Requester still asserting req in its ack cycle starts a new transaction at next IDLE edge.
REQ-023 rdata unchanged by writes; holds last read value until the next read completes.
REQ-024 cpu_ack and dma_ack never high together; busy = state!=IDLE.
REQ-025 Simultaneous requests resolved per REQ-030/REQ-031; loser waits, no request lost.

Reset
REQ-026 init high forces immediately: state IDLE, cnt 0, cpu_ack 0, dma_ack 0, rdata 0, mem_addr 0, mem_do 0, mem_wr 0, grant 0, busy 0, last-grant register 1.
REQ-027 init mid-transaction aborts it: mem_wr drops asynchronously, no ack issued after release.
REQ-028 First arbitration at first rising edge with init low.

Configuration
REQ-029 Macro ERM16_ARB_RR_EN selects arbitration policy.
REQ-030 Defined: round-robin; last-grant register updated on each grant; on simultaneous requests the requester not last granted wins; CPU wins first contest after reset.
REQ-031 Undefined: fixed priority, CPU always wins on simultaneous requests; last-grant register absent; DMA may starve.

Verification
REQ-032 WAIT_STATES=1, CPU read addr 0x0040, mem_di=0xBEEF -> mem_addr=0x0040, mem_wr low, cpu_ack one cycle after edge k+2, rdata=0xBEEF.
REQ-033 DMA write addr 0x1234 data 0x5A5A -> grant=1, mem_wr high exactly 2 cycles, mem_do=0x5A5A, dma_ack one cycle, rdata unchanged.
REQ-034 Both req held continuously, 4 transactions -> RR_EN: grants CPU,DMA,CPU,DMA; no RR_EN: CPU,CPU,CPU,CPU, dma_ack never.
REQ-035 init pulsed during write WAIT cycle -> mem_wr 0 immediately, all outputs at reset values, no ack after release.
REQ-036 WAIT_STATES=0, CPU read with req dropped after grant -> cpu_ack one cycle after edge k+1, busy high 2 cycles.

Source files
------------

// File: rtl/erm16_bus_arbiter.sv
// Two-master (CPU/DMA) single-port memory arbiter; ERM16_ARB_RR_EN selects round-robin, else CPU fixed priority.
// Latency: request at IDLE edge k -> ack in the cycle after edge k+WAIT_STATES+1; all outputs registered.
// Backpressure: requesters hold req/operands until their one-cycle ack; losers simply wait for the next IDLE.
module erm16_bus_arbiter #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        init,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_ack,
    output logic [15:0] rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_do,
    output logic        mem_wr,
    input  logic [15:0] mem_di,
    output logic        grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] WS_L = WAIT_STATES[3:0];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_do_q, mem_do_d;
    logic [15:0] rdata_q, rdata_d;
    logic        mem_wr_q, mem_wr_d;
    logic        grant_q, grant_d;
    logic        busy_q, busy_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        dma_ack_q, dma_ack_d;
    logic        any_req;
    logic        pick_dma;

`ifdef ERM16_ARB_RR_EN
    // last_q = 1 means the DMA owned the bus most recently, so the CPU wins the next tie.
    logic last_q, last_d;

    always_comb begin
        pick_dma = dma_req & (~cpu_req | ~last_q);
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        pick_dma = dma_req & ~cpu_req;
    end
`endif

    always_comb begin
        any_req    = cpu_req | dma_req;
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        mem_addr_d = mem_addr_q;
        mem_do_d   = mem_do_q;
        rdata_d    = rdata_q;
        mem_wr_d   = mem_wr_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        cpu_ack_d  = 1'b0;
        dma_ack_d  = 1'b0;
`ifdef ERM16_ARB_RR_EN
        last_d     = last_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d    = pick_dma;
                    we_d       = pick_dma ? dma_we    : cpu_we;
                    mem_addr_d = pick_dma ? dma_addr  : cpu_addr;
                    mem_do_d   = pick_dma ? dma_wdata : cpu_wdata;
                    mem_wr_d   = pick_dma ? dma_we    : cpu_we;
                    cnt_d      = WS_L;
                    busy_d     = 1'b1;
                    state_d    = S_WAIT;
`ifdef ERM16_ARB_RR_EN
                    last_d     = pick_dma;
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!we_q) begin
                        rdata_d = mem_di;
                    end
                    mem_wr_d  = 1'b0;
                    cpu_ack_d = ~grant_q;
                    dma_ack_d = grant_q;
                    state_d   = S_ACK;
                end
            end
            S_ACK: begin
                // Requests seen here are deliberately ignored; they get arbitrated next IDLE.
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                mem_wr_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            mem_addr_q <= 16'h0000;
            mem_do_q   <= 16'h0000;
            rdata_q    <= 16'h0000;
            mem_wr_q   <= 1'b0;
            grant_q    <= 1'b0;
            busy_q     <= 1'b0;
            cpu_ack_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            mem_addr_q <= mem_addr_d;
            mem_do_q   <= mem_do_d;
            rdata_q    <= rdata_d;
            mem_wr_q   <= mem_wr_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            cpu_ack_q  <= cpu_ack_d;
            dma_ack_q  <= dma_ack_d;
        end
    end

    assign cpu_ack  = cpu_ack_q;
    assign dma_ack  = dma_ack_q;
    assign rdata    = rdata_q;
    assign mem_addr = mem_addr_q;
    assign mem_do   = mem_do_q;
    assign mem_wr   = mem_wr_q;
    assign grant    = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_erm16_bus_arbiter.sv
// Scoreboard bench for erm16_bus_arbiter: one instance with WAIT_STATES=1, one with WAIT_STATES=0.
module tb_erm16_bus_arbiter;

    localparam int WS = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        init;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_ack, dma_ack, mem_wr, grant, busy;
    logic [15:0] rdata, mem_addr, mem_do, mem_di;

    logic        cpu_req_z, cpu_we_z, dma_req_z, dma_we_z;
    logic [15:0] cpu_addr_z, cpu_wdata_z, dma_addr_z, dma_wdata_z;
    logic        cpu_ack_z, dma_ack_z, mem_wr_z, grant_z, busy_z;
    logic [15:0] rdata_z, mem_addr_z, mem_do_z, mem_di_z;

    function automatic logic [15:0] mem_model(input logic [15:0] a);
        return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hA5C3);
    endfunction

    assign mem_di   = mem_model(mem_addr);
    assign mem_di_z = mem_model(mem_addr_z);

    erm16_bus_arbiter #(.WAIT_STATES(WS)) dut (
        .clk(clk), .init(init),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .rdata(rdata), .mem_addr(mem_addr), .mem_do(mem_do), .mem_wr(mem_wr), .mem_di(mem_di),
        .grant(grant), .busy(busy)
    );

    erm16_bus_arbiter #(.WAIT_STATES(0)) dut_z (
        .clk(clk), .init(init),
        .cpu_req(cpu_req_z), .cpu_we(cpu_we_z), .cpu_addr(cpu_addr_z), .cpu_wdata(cpu_wdata_z), .cpu_ack(cpu_ack_z),
        .dma_req(dma_req_z), .dma_we(dma_we_z), .dma_addr(dma_addr_z), .dma_wdata(dma_wdata_z), .dma_ack(dma_ack_z),
        .rdata(rdata_z), .mem_addr(mem_addr_z), .mem_do(mem_do_z), .mem_wr(mem_wr_z), .mem_di(mem_di_z),
        .grant(grant_z), .busy(busy_z)
    );

    typedef struct {
        logic        who;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    logic [15:0] last_rd = 16'h0000;
    logic        rr_last = 1'b1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic who, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        exp_t e;
        e.who   = who;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        if (we) begin
            e.rdata = last_rd;
        end else begin
            e.rdata = mem_model(addr);
            last_rd = e.rdata;
        end
        rr_last = who;
        sb_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mem_wr) wr_cnt++;
            if (cpu_ack && dma_ack) chk("ack_exclusive", 1, 0);
            if (cpu_ack || dma_ack) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_ack", {30'd0, cpu_ack, dma_ack}, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ack_owner", dma_ack, e.who);
                    chk("grant", grant, e.who);
                    chk("mem_addr", mem_addr, e.addr);
                    if (e.we) chk("mem_do", mem_do, e.wdata);
                    chk("wr_cycles", wr_cnt, e.we ? WS + 1 : 0);
                    chk("rdata", rdata, e.rdata);
                    chk("busy_in_ack", busy, 1);
                end
                wr_cnt = 0;
            end
        end
    end

    task automatic run_one(input logic who, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        int  c0;
        bit  got;
        push_exp(who, we, addr, wdata);
        @(posedge clk);
        #2;
        if (who) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        c0  = cyc;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (who ? dma_ack : cpu_ack) begin
                got = 1;
                break;
            end
        end
        chk("ack_timeout", got, 1);
        if (got) chk("latency", cyc - c0, WS + 2);
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    task automatic contend(input int n);
        int  acks;
        logic w;
        for (int i = 0; i < n; i++) begin
`ifdef ERM16_ARB_RR_EN
            w = ~rr_last;
`else
            w = 1'b0;
`endif
            if (w) push_exp(1'b1, 1'b1, 16'h0200, 16'h3C3C);
            else   push_exp(1'b0, 1'b0, 16'h0100, 16'h0000);
        end
        @(posedge clk);
        #2;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100; cpu_wdata = 16'h0000;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0200; dma_wdata = 16'h3C3C;
        acks = 0;
        for (int i = 0; i < 15 * n; i++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) acks++;
            if (acks == n) break;
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        chk("contend_acks", acks, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        int          busy_cnt;
        int          ack_cnt;
        int          ack_cyc;
        bit          got;
        logic        who;
        logic        we;
        logic [15:0] addr;

        init = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040; cpu_wdata = 16'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0;    dma_wdata = 16'h0;
        cpu_req_z = 1'b0; cpu_we_z = 1'b0; cpu_addr_z = 16'h0; cpu_wdata_z = 16'h0;
        dma_req_z = 1'b0; dma_we_z = 1'b0; dma_addr_z = 16'h0; dma_wdata_z = 16'h0;

        // Reset state, with a request pending that must be ignored through an edge
        #8;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_do", mem_do, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_acks", {cpu_ack, dma_ack}, 0);
        chk("rst_busy_z", busy_z, 0);
        cpu_req = 1'b0;
        @(posedge clk);
        #2 init = 1'b0;

        run_one(1'b0, 1'b0, 16'h0040, 16'h0000);
        chk("read_beef", rdata, 16'hBEEF);
        run_one(1'b1, 1'b1, 16'h1234, 16'h5A5A);
        chk("write_keeps_rdata", rdata, 16'hBEEF);

        for (int i = 0; i < 4; i++) begin
            who  = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            addr = 16'($urandom);
            run_one(who, we, addr, 16'($urandom));
        end
        run_one(1'b1, 1'b0, 16'h0300, 16'h0000);

        contend(4);

        // Reset in the middle of a write
        @(posedge clk);
        #2;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0777; cpu_wdata = 16'h1111;
        got = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_wr) begin
                got = 1;
                break;
            end
        end
        chk("abort_wr_seen", got, 1);
        #2 init = 1'b1;
        #1;
        chk("abort_mem_wr", mem_wr, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_mem_do", mem_do, 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_grant", grant, 0);
        cpu_req = 1'b0;
        wr_cnt  = 0;
        last_rd = 16'h0000;
        rr_last = 1'b1;
        @(posedge clk);
        #2 init = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cpu_ack || dma_ack) ack_cnt++;
        end
        chk("no_ack_after_abort", ack_cnt, 0);

        contend(2);

        // Zero wait states, request dropped right after grant
        @(posedge clk);
        #2;
        cpu_req_z = 1'b1; cpu_we_z = 1'b0; cpu_addr_z = 16'h0ABC;
        c0 = cyc;
        @(posedge clk);
        #2 cpu_req_z = 1'b0;
        busy_cnt = 0;
        ack_cnt  = 0;
        ack_cyc  = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy_z) busy_cnt++;
            if (cpu_ack_z) begin
                ack_cnt++;
                ack_cyc = cyc;
                chk("z_rdata", rdata_z, mem_model(16'h0ABC));
            end
            if (dma_ack_z) chk("z_dma_ack", dma_ack_z, 0);
        end
        chk("z_ack_count", ack_cnt, 1);
        chk("z_latency", ack_cyc - c0, 2);
        chk("z_busy_cycles", busy_cnt, 2);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
